// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin grant arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned NUM_REQ_MIN  = 2;
  localparam int unsigned NUM_REQ_MAX  = 16;
  localparam int unsigned MAX_HOLD_MIN = 1;
  localparam int unsigned MAX_HOLD_MAX = 255;

  // Index width for a requester vector; never below 1 bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tenure counter width able to hold MAX_HOLD without wrapping.
  function automatic int unsigned cnt_width(input int unsigned m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  localparam int unsigned ID_W_DEFAULT  = id_width(4);
  localparam int unsigned CNT_W_DEFAULT = cnt_width(8);

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set bit of req & ~excl,
// searching upward from start with wrap-around.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [id_width(NUM_REQ)-1:0] start_i,
  input  logic [NUM_REQ-1:0]           excl_i,
  output logic [id_width(NUM_REQ)-1:0] idx_o,
  output logic                         found_o
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] cand;
  int unsigned        j;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    j       = 0;
    cand    = req_i & ~excl_i;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = int'(start_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found_o && cand[ID_W'(j)]) begin
        found_o = 1'b1;
        idx_o   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin request/grant arbiter with bounded tenure and registered grant.
// Define ARB_ASSERT_EN to compile in the runtime consistency assertions.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           request,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         grant_valid,
  output logic [id_width(NUM_REQ)-1:0] grant_id
);

  localparam int unsigned      ID_W     = id_width(NUM_REQ);
  localparam int unsigned      CNT_W    = cnt_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0] excl;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               owner_req;
  logic               take;

  // Excluding the current owner makes one search serve both release and expiry.
  assign excl = (state_q == BUSY) ? grant_q : '0;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (request),
    .start_i (ptr_q),
    .excl_i  (excl),
    .idx_o   (win),
    .found_o (found)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    take      = 1'b0;
    owner_req = request[id_q];

    case (state_q)
      IDLE: begin
        if (found) take = 1'b1;
      end
      BUSY: begin
        if (!owner_req) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            cnt_d   = '0;
          end
        end else if ((cnt_q == HOLD_MAX) && found) begin
          take = 1'b1;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = BUSY;
      grant_d = NUM_REQ'(1) << win;
      id_d    = win;
      cnt_d   = CNT_W'(1);
      ptr_d   = (win == LAST_ID) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = id_q;

`ifdef ARB_ASSERT_EN
  logic [NUM_REQ-1:0] req_prev_q;
  logic [NUM_REQ-1:0] grant_prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(grant_q));
      assert (grant_valid == |grant_q);
      assert (!grant_valid || grant_q[id_q]);
      assert (cnt_q <= HOLD_MAX);
      assert (((grant_q & ~grant_prev_q) & ~req_prev_q) == '0);
    end
    req_prev_q   <= request;
    grant_prev_q <= grant_q;
  end
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter (NUM_REQ=4, MAX_HOLD=8).
module tb_rr_grant_arbiter;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];

  rr_grant_arbiter #(
    .NUM_REQ  (4),
    .MAX_HOLD (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] onehot_idx(input logic [3:0] v);
    logic [31:0] r;
    r = 0;
    for (int b = 0; b < 4; b++) if (v[b]) r = b;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the grant expected after the edge,
  // then pop it and compare once the edge has passed.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic [3:0] exp,
                     input string tag);
    logic [3:0] e;
    reset   = rst;
    request = req;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".grant"}, 32'(grant), 32'(e));
    check({tag, ".valid"}, 32'(grant_valid), 32'(|e));
    check({tag, ".id"}, 32'(grant_id), onehot_idx(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    request = 4'b1111;
    @(negedge clk);

    cyc(1'b1, 4'b1111, 4'b0000, "rst0");
    cyc(1'b1, 4'b1111, 4'b0000, "rst1");
    check("rst.state", 32'(dut.state_q), 32'(IDLE));
    check("rst.ptr", 32'(dut.ptr_q), 32'd0);
    check("rst.cnt", 32'(dut.cnt_q), 32'd0);

    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 8; t++) cyc(1'b0, 4'b1111, 4'(1 << k), $sformatf("full%0d_%0d", k, t));
    end
    cyc(1'b0, 4'b1111, 4'b0001, "full_wrap");
    cyc(1'b0, 4'b0000, 4'b0000, "full_drop");

    for (int t = 0; t < 5; t++) cyc(1'b0, 4'b0010, 4'b0010, $sformatf("rel%0d", t));
    cyc(1'b0, 4'b0000, 4'b0000, "rel_drop");
    check("rel.state", 32'(dut.state_q), 32'(IDLE));

    for (int t = 0; t < 20; t++) cyc(1'b0, 4'b0100, 4'b0100, $sformatf("sole%0d", t));
    check("sole.cnt", 32'(dut.cnt_q), 32'd8);
    cyc(1'b0, 4'b0000, 4'b0000, "sole_drop");

    cyc(1'b0, 4'b0010, 4'b0010, "sim_own1");
    cyc(1'b0, 4'b0010, 4'b0010, "sim_hold1");
    check("sim.ptr", 32'(dut.ptr_q), 32'd2);
    cyc(1'b0, 4'b1001, 4'b1000, "sim_hand3");
    cyc(1'b0, 4'b1001, 4'b1000, "sim_hold3");
    cyc(1'b0, 4'b0001, 4'b0001, "sim_to0");

    cyc(1'b0, 4'b1000, 4'b1000, "mid_own3");
    cyc(1'b0, 4'b1001, 4'b1000, "mid_hold3");
    cyc(1'b1, 4'b1001, 4'b0000, "mid_rst");
    check("mid.ptr", 32'(dut.ptr_q), 32'd0);
    cyc(1'b0, 4'b1001, 4'b0001, "mid_rel");
    for (int t = 0; t < 7; t++) cyc(1'b0, 4'b1001, 4'b0001, $sformatf("exp_hold%0d", t));
    cyc(1'b0, 4'b1001, 4'b1000, "exp_hand3");
    cyc(1'b0, 4'b0000, 4'b0000, "end_drop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
